// File: rtl/fetch_queue.sv
// fetch_queue: keeps the fetch PC and issues one-word instruction cache
// requests, with at most one request in flight. Returned instructions are
// buffered with their PC+4 in a small FIFO, and the FIFO head is presented
// first-word-fall-through to the dispatcher. A dispatcher jump/branch flushes
// the FIFO and steers fetch to the new target. If a request is still in
// flight when the jump arrives, its late response is thrown away.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] icache_addr,
  output logic        icache_rd_en,
  input  logic [31:0] icache_data,
  input  logic        icache_valid,
  output logic [31:0] o_fetch_instruction,
  output logic [31:0] o_fetch_pc_plus_4,
  output logic        o_fetch_empty_flag,
  input  logic        dispatch_rd_en,
  input  logic        dispatch_jmp_valid,
  input  logic [31:0] dispatch_jmp_br_addr
);

  localparam int                AW         = $clog2(DEPTH);
  localparam int                CW         = AW + 1;
  localparam logic [CW-1:0]     FULL_COUNT = CW'(DEPTH);

  // FETCH: nothing outstanding; WAIT: one live request; DROP: one squashed request
  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DROP
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic [31:0]   next_pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc4   [DEPTH];

  logic has_space;
  logic issue;
  logic push;
  logic pop;

  // A redirect overrides everything in its cycle. While it is asserted, no
  // request is issued, no response is queued and no entry is popped.
  assign next_pc   = req_pc + 32'd4;
  assign has_space = (count < FULL_COUNT);
  assign issue     = i_rst_n & (state == FETCH) & has_space & ~dispatch_jmp_valid;
  assign push      = (state == WAIT) & icache_valid & ~dispatch_jmp_valid;
  assign pop       = dispatch_rd_en & ~o_fetch_empty_flag & ~dispatch_jmp_valid;

  assign icache_rd_en        = issue;
  assign icache_addr         = pc;
  assign o_fetch_empty_flag  = (count == '0);
  assign o_fetch_instruction = mem_instr[rd_ptr];
  assign o_fetch_pc_plus_4   = mem_pc4[rd_ptr];

  // Fetch sequencer: tracks the outstanding request and advances the fetch PC
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (dispatch_jmp_valid) begin
      pc <= dispatch_jmp_br_addr & ~32'h3;
      if (state == FETCH) begin
        state <= FETCH;
      end else if (icache_valid) begin
        state <= FETCH;
      end else begin
        state <= DROP;
      end
    end else begin
      case (state)
        FETCH: begin
          if (issue) begin
            req_pc <= pc;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (icache_valid) begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        DROP: begin
          if (icache_valid) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Instruction FIFO: a flush moves the read pointer up to the write pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc4[i]   <= '0;
      end
    end else if (dispatch_jmp_valid) begin
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= icache_data;
        mem_pc4[wr_ptr]   <= next_pc;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue. It models an instruction cache with
// programmable latency. Directed phases push the expected request addresses
// and expected popped entries into queues. A monitor pops those queues and
// compares them whenever the DUT issues a request or the dispatcher pops.
module tb_fetch_queue;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] icache_addr;
  logic        icache_rd_en;
  logic [31:0] icache_data;
  logic        icache_valid;
  logic [31:0] o_fetch_instruction;
  logic [31:0] o_fetch_pc_plus_4;
  logic        o_fetch_empty_flag;
  logic        dispatch_rd_en;
  logic        dispatch_jmp_valid;
  logic [31:0] dispatch_jmp_br_addr;

  int          n_cmp     = 0;
  int          n_fail    = 0;
  int          pops_seen = 0;
  int          lat       = 1;
  int          rem       = 0;
  logic        pend      = 1'b0;
  logic [31:0] pend_addr = '0;

  logic [31:0] exp_addr_q [$];
  logic [63:0] exp_pop_q  [$];

  fetch_queue #(
    .DEPTH   (4),
    .RESET_PC(32'h0040_0000)
  ) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .icache_addr         (icache_addr),
    .icache_rd_en        (icache_rd_en),
    .icache_data         (icache_data),
    .icache_valid        (icache_valid),
    .o_fetch_instruction (o_fetch_instruction),
    .o_fetch_pc_plus_4   (o_fetch_pc_plus_4),
    .o_fetch_empty_flag  (o_fetch_empty_flag),
    .dispatch_rd_en      (dispatch_rd_en),
    .dispatch_jmp_valid  (dispatch_jmp_valid),
    .dispatch_jmp_br_addr(dispatch_jmp_br_addr)
  );

  // Free-running clock with a 10-unit period
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // The instruction word the cache returns for a given address
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // The FIFO entry a fetch of address a should produce
  function automatic logic [63:0] ent(input logic [31:0] a);
    return {a + 32'd4, instr_of(a)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic jmp, input logic [31:0] tgt);
    @(posedge i_clk);
    #1;
    dispatch_rd_en       = rd;
    dispatch_jmp_valid   = jmp;
    dispatch_jmp_br_addr = tgt;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 32'h0);
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  task automatic checkDrained(input string name);
    checkOutput({name, "_addr_q_left"}, 32'(exp_addr_q.size()), 32'd0);
    checkOutput({name, "_pop_q_left"}, 32'(exp_pop_q.size()), 32'd0);
  endtask

  // Cache model: captures a request at the negedge, then answers it with a
  // one-cycle valid pulse lat cycles later. An in-flight request is forgotten
  // when reset is asserted.
  initial begin
    icache_valid = 1'b0;
    icache_data  = '0;
    forever begin
      @(negedge i_clk);
      if (icache_rd_en) begin
        pend      = 1'b1;
        rem       = lat;
        pend_addr = icache_addr;
      end
      @(posedge i_clk);
      #1;
      icache_valid = 1'b0;
      if (!i_rst_n) begin
        pend = 1'b0;
      end else if (pend) begin
        rem--;
        if (rem == 0) begin
          icache_valid = 1'b1;
          icache_data  = instr_of(pend_addr);
          pend         = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every issued request and every dispatcher pop
  always @(negedge i_clk) begin
    if (icache_rd_en) begin
      if (exp_addr_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_request: got addr %h expected no request", icache_addr);
      end else begin
        checkOutput("icache_addr", icache_addr, exp_addr_q.pop_front());
      end
    end
    if (i_rst_n && dispatch_rd_en && !o_fetch_empty_flag && !dispatch_jmp_valid) begin
      pops_seen++;
      if (exp_pop_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_pop: got pc_plus_4 %h expected no pop", o_fetch_pc_plus_4);
      end else begin
        logic [63:0] e;
        e = exp_pop_q.pop_front();
        checkOutput("pop_pc_plus_4", o_fetch_pc_plus_4, e[63:32]);
        checkOutput("pop_instr", o_fetch_instruction, e[31:0]);
      end
    end
  end

  // Directed test sequence
  initial begin
    int target;
    int guard;

    i_rst_n              = 1'b1;
    dispatch_rd_en       = 1'b0;
    dispatch_jmp_valid   = 1'b0;
    dispatch_jmp_br_addr = '0;

    // Reset values, checked before any clock edge
    #1 i_rst_n = 1'b0;
    #1;
    checkOutput("rst_empty", 32'(o_fetch_empty_flag), 32'd1);
    checkOutput("rst_instr", o_fetch_instruction, 32'h0);
    checkOutput("rst_pc4", o_fetch_pc_plus_4, 32'h0);
    checkOutput("rst_rd_en", 32'(icache_rd_en), 32'd0);
    sample();
    checkOutput("rst_rd_en_held", 32'(icache_rd_en), 32'd0);

    // Phase 1: steady fetch at L=1 until the FIFO is full
    lat = 1;
    exp_addr_q.push_back(32'h0040_0000);
    exp_addr_q.push_back(32'h0040_0004);
    exp_addr_q.push_back(32'h0040_0008);
    exp_addr_q.push_back(32'h0040_000C);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    idle(12);
    sample();
    checkOutput("p1_empty", 32'(o_fetch_empty_flag), 32'd0);
    checkOutput("p1_head_pc4", o_fetch_pc_plus_4, 32'h0040_0004);
    checkOutput("p1_head_instr", o_fetch_instruction, instr_of(32'h0040_0000));
    checkOutput("p1_full_rd_en", 32'(icache_rd_en), 32'd0);
    checkDrained("p1");

    // Phase 2: one pop from a full FIFO frees room for exactly one fetch
    exp_pop_q.push_back(ent(32'h0040_0000));
    exp_addr_q.push_back(32'h0040_0010);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    sample();
    checkOutput("p2_head_pc4", o_fetch_pc_plus_4, 32'h0040_0008);
    checkOutput("p2_head_instr", o_fetch_instruction, instr_of(32'h0040_0004));
    idle(4);
    sample();
    checkDrained("p2");

    // Phase 3: redirect while waiting at L=3; the stale response is dropped
    lat = 3;
    exp_pop_q.push_back(ent(32'h0040_0004));
    exp_addr_q.push_back(32'h0040_0014);
    exp_addr_q.push_back(32'h0040_0100);
    exp_addr_q.push_back(32'h0040_0104);
    exp_addr_q.push_back(32'h0040_0108);
    exp_addr_q.push_back(32'h0040_010C);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0040_0101);
    applyStimulus(1'b0, 1'b0, 32'h0);
    sample();
    checkOutput("p3_flush_empty", 32'(o_fetch_empty_flag), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    sample();
    checkOutput("p3_stale_cycle_empty", 32'(o_fetch_empty_flag), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    sample();
    checkOutput("p3_stale_not_pushed", 32'(o_fetch_empty_flag), 32'd1);
    idle(3);
    applyStimulus(1'b0, 1'b0, 32'h0);
    sample();
    checkOutput("p3_first_empty", 32'(o_fetch_empty_flag), 32'd0);
    checkOutput("p3_first_pc4", o_fetch_pc_plus_4, 32'h0040_0104);
    checkOutput("p3_first_instr", o_fetch_instruction, instr_of(32'h0040_0100));
    idle(15);
    sample();
    checkDrained("p3");

    // Phase 4: redirect coincides with icache_valid; target wraps the PC
    lat = 2;
    exp_pop_q.push_back(ent(32'h0040_0100));
    exp_addr_q.push_back(32'h0040_0110);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0000_0000);
    exp_addr_q.push_back(32'h0000_0004);
    exp_addr_q.push_back(32'h0000_0008);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE);
    applyStimulus(1'b0, 1'b0, 32'h0);
    sample();
    checkOutput("p4_flush_empty", 32'(o_fetch_empty_flag), 32'd1);
    idle(2);
    applyStimulus(1'b0, 1'b0, 32'h0);
    sample();
    checkOutput("p4_wrap_empty", 32'(o_fetch_empty_flag), 32'd0);
    checkOutput("p4_wrap_pc4", o_fetch_pc_plus_4, 32'h0000_0000);
    checkOutput("p4_wrap_instr", o_fetch_instruction, instr_of(32'hFFFF_FFFC));
    idle(12);
    sample();
    checkDrained("p4");

    // Phase 5: continuous pop at L=1, twenty instructions across pointer wrap
    lat = 1;
    for (int k = 0; k < 24; k++) exp_addr_q.push_back(32'h0000_1000 + 32'(4 * k));
    for (int k = 0; k < 20; k++) exp_pop_q.push_back(ent(32'h0000_1000 + 32'(4 * k)));
    target = pops_seen + 20;
    applyStimulus(1'b0, 1'b1, 32'h0000_1000);
    applyStimulus(1'b1, 1'b0, 32'h0);
    sample();
    checkOutput("p5_req_cycle_empty", 32'(o_fetch_empty_flag), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    sample();
    checkOutput("p5_resp_cycle_empty", 32'(o_fetch_empty_flag), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    sample();
    checkOutput("p5_visible_empty", 32'(o_fetch_empty_flag), 32'd0);
    checkOutput("p5_visible_pc4", o_fetch_pc_plus_4, 32'h0000_1004);
    #1;
    guard = 0;
    while (pops_seen < target && guard < 80) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      sample();
      #1;
      guard++;
    end
    checkOutput("p5_pop_count", 32'(pops_seen), 32'(target));
    applyStimulus(1'b0, 1'b0, 32'h0);
    idle(12);
    sample();
    checkDrained("p5");

    // Phase 6: asynchronous reset in the middle of WAIT with a non-empty FIFO
    lat = 3;
    exp_pop_q.push_back(ent(32'h0000_1050));
    exp_addr_q.push_back(32'h0000_1060);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("p6_async_empty", 32'(o_fetch_empty_flag), 32'd1);
    checkOutput("p6_async_instr", o_fetch_instruction, 32'h0);
    checkOutput("p6_async_pc4", o_fetch_pc_plus_4, 32'h0);
    checkOutput("p6_async_rd_en", 32'(icache_rd_en), 32'd0);
    idle(2);
    sample();
    checkOutput("p6_held_rd_en", 32'(icache_rd_en), 32'd0);
    lat = 1;
    exp_addr_q.push_back(32'h0040_0000);
    exp_addr_q.push_back(32'h0040_0004);
    exp_addr_q.push_back(32'h0040_0008);
    exp_addr_q.push_back(32'h0040_000C);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    idle(12);
    sample();
    checkOutput("p6_head_pc4", o_fetch_pc_plus_4, 32'h0040_0004);
    checkOutput("p6_head_instr", o_fetch_instruction, instr_of(32'h0040_0000));
    checkDrained("p6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
